qu_fetch_ctrl: RTL
==================

// Module: qu_fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer for the Qu core. Owns the PC and issues in-order
//   word fetches to instruction memory over a valid/ready request channel. Buffers
//   returned words in a small FIFO and presents {instr, pc} to decode over a
//   valid/ready handshake. Applies branch/jump/trap redirects with a flush of all
//   stale in-flight fetches.
// PARAMETERS
//   PC_WIDTH     QU_PC_WIDTH (12)      byte-address width of PC and imem address
//   PC_RESET     QU_PC_RESET_VAL (0)   PC value after reset
//   BUF_DEPTH    2                     max (outstanding fetches + buffered words), >=1
// PORTS
//   clk              in   1          clock, all state on rising edge
//   rst_n            in   1          asynchronous, active-low reset
//   imem_req_valid   out  1          fetch request valid
//   imem_req_ready   in   1          memory accepts request
//   imem_req_addr    out  PC_WIDTH   fetch byte address, word aligned
//   imem_rsp_valid   in   1          response valid, in request order, latency >=1
//   imem_rsp_data    in   32         fetched instruction (instr_t)
//   redirect_valid   in   1          redirect PC, single-cycle pulse
//   redirect_pc      in   PC_WIDTH   redirect target, [1:0] ignored (forced 0)
//   instr_valid      out  1          FIFO head valid to decode
//   instr_ready      in   1          decode consumes head
//   instr_data       out  32         head instruction
//   instr_pc         out  PC_WIDTH   PC of head instruction
// BEHAVIOUR
//   Reset: pc=PC_RESET, FIFO empty, outstanding=0, drop_cnt=0, state=BOOT;
//     imem_req_valid=0, imem_req_addr=PC_RESET, instr_valid=0, instr_data=0, instr_pc=0.
//   FSM: BOOT -> FETCH unconditionally after 1 cycle.
//     FETCH -> FLUSH on redirect when in-flight responses remain (drop_cnt>0 after update).
//     FLUSH -> FETCH in the cycle the last dropped response arrives (drop_cnt 1->0).
//   Issue rule (FETCH only): imem_req_valid=1 iff
//     outstanding + occupancy - (instr_valid&instr_ready) < BUF_DEPTH and no redirect this cycle.
//   Request accepted on valid&ready: outstanding+1, pc <= pc+4 (wraps mod 2^PC_WIDTH).
//   Unaccepted request holds addr stable; only a redirect may withdraw it.
//   Response: outstanding-1; if drop_cnt>0 discard and drop_cnt-1, else push {data, pc}.
//     Fetch-PC queue (depth BUF_DEPTH) tracks PC per outstanding request.
//   Output: registered FIFO head; pop on instr_valid&instr_ready. No rsp->instr bypass.
//     Throughput with 1-cycle memory and BUF_DEPTH=2: 1 instr/cycle sustained.
//   Redirect: pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}; FIFO flushed; drop_cnt <= outstanding
//     minus any response arriving same cycle; no request issued that cycle.
//   Simultaneous: redirect + pop -> pop counts, FIFO flushed anyway. Redirect + rsp -> rsp
//     dropped. Redirect in FLUSH -> pc updated, drop_cnt unchanged (no new issues in FLUSH).
//   Full (outstanding+occupancy=BUF_DEPTH): no issue; pop in same cycle re-enables issue.
//   Reset asserted mid-operation: all state to reset values immediately; later late
//     responses are the memory's responsibility (memory is reset on the same rst_n).
// CONFIGURATION
//   QU_FETCH_JAL_PREDICT_EN defined: pushed non-dropped word with opcode==JAL_OPCODE
//     acts as internal redirect to its pc + sext(imm21): the JAL itself is pushed and
//     kept; younger entries are flushed and younger in-flight responses are dropped.
//     External redirect in same cycle takes priority.
//   Undefined: JAL handled like any other word; only redirect_valid changes PC flow.
// TESTING
//   Reset: rst_n=0 mid-stream -> req_valid=0, instr_valid=0; first req after release addr 0x000.
//   Stream, 1-cycle mem, ready=1 -> req addrs 0x000,0x004,0x008...; instr_pc same order, 1/cycle.
//   Backpressure: instr_ready=0 -> exactly 2 reqs (0x000,0x004); req_valid stays 0; head pc 0x000.
//   Redirect 0x100 with 2 outstanding -> FLUSH, 2 rsps dropped; next req 0x100, first instr_pc 0x100.
//   Wrap: redirect 0xFFD -> req 0xFFC then 0x000; instr_pc 0xFFC then 0x000.
//   PREDICT_EN: JAL at 0x010, imm21=+0x20 -> next req 0x030; word at 0x014 never presented.

Source files
------------

// File: rtl/qu_fetch_ctrl_if.sv
// qu_fetch_ctrl_if: instruction-memory request/response, redirect and decode channels
// of the Qu fetch sequencer; master is the fetch controller, slave is its environment.
interface qu_fetch_ctrl_if #(parameter int PC_WIDTH = 12);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [PC_WIDTH-1:0] imem_req_addr;
    logic                imem_rsp_valid;
    logic [31:0]         imem_rsp_data;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                instr_valid;
    logic                instr_ready;
    logic [31:0]         instr_data;
    logic [PC_WIDTH-1:0] instr_pc;
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/qu_fetch_ctrl.sv
// qu_fetch_ctrl: PC owner, in-order imem fetch issue, response FIFO to decode, redirect flush.
// Define QU_FETCH_JAL_PREDICT_EN to redirect on buffered JAL words to their static target.
module qu_fetch_ctrl #(
    parameter int                  PC_WIDTH  = 12,
    parameter logic [PC_WIDTH-1:0] PC_RESET  = '0,
    parameter int                  BUF_DEPTH = 2
) (
    input logic             clk,
    input logic             rst_n,
    qu_fetch_ctrl_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH + 1) + 1;
    localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam logic [1:0] BOOT = 2'd0, FETCH = 2'd1, FLUSH = 2'd2;
    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, jal_pc;
    logic [CW-1:0]       out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d, prd_q, prd_d, pwr_q, pwr_d;
    logic [31:0]         fd_q [BUF_DEPTH];
    logic [PC_WIDTH-1:0] fp_q [BUF_DEPTH];
    logic [PC_WIDTH-1:0] pq_q [BUF_DEPTH];
    logic                pop, rsp, keep, jal, flush, acc;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign pop   = bus.instr_valid & bus.instr_ready;
    assign rsp   = bus.imem_rsp_valid;
    assign keep  = rsp && drop_q == '0 && !bus.redirect_valid;
`ifdef QU_FETCH_JAL_PREDICT_EN
    localparam logic [6:0] JAL_OPCODE = 7'b1101111;
    assign jal    = keep && bus.imem_rsp_data[6:0] == JAL_OPCODE;
    assign jal_pc = pq_q[prd_q] + PC_WIDTH'({{12{bus.imem_rsp_data[31]}}, bus.imem_rsp_data[19:12],
                    bus.imem_rsp_data[20], bus.imem_rsp_data[30:21], 1'b0});
`else
    assign jal    = 1'b0;
    assign jal_pc = pq_q[prd_q];
`endif
    assign flush = bus.redirect_valid | jal;
    // Slots freed by a same-cycle pop count, so a full buffer keeps streaming.
    assign bus.imem_req_valid = state_q == FETCH && !flush && (out_q + cnt_q - CW'(pop)) < CW'(BUF_DEPTH);
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = cnt_q != '0;
    assign bus.instr_data     = fd_q[rd_q];
    assign bus.instr_pc       = fp_q[rd_q];
    assign acc = bus.imem_req_valid & bus.imem_req_ready;
    always_comb begin
        out_d   = out_q + CW'(acc) - CW'(rsp);
        drop_d  = bus.redirect_valid ? out_q - CW'(rsp) : jal ? out_q - CW'(1) : drop_q - CW'(rsp && drop_q != '0);
        cnt_d   = bus.redirect_valid ? '0 : cnt_q + CW'(keep) - CW'(pop);
        rd_d    = bus.redirect_valid ? wr_q : pop ? inc(rd_q) : rd_q;
        wr_d    = bus.redirect_valid ? wr_q : keep ? inc(wr_q) : wr_q;
        prd_d   = rsp ? inc(prd_q) : prd_q;
        pwr_d   = acc ? inc(pwr_q) : pwr_q;
        pc_d    = bus.redirect_valid ? bus.redirect_pc & ~PC_WIDTH'(3) :
                  jal ? jal_pc & ~PC_WIDTH'(3) : acc ? pc_q + PC_WIDTH'(4) : pc_q;
        state_d = drop_d != '0 ? FLUSH : FETCH;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= PC_RESET;
            out_q   <= '0;
            drop_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            prd_q   <= '0;
            pwr_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fd_q[i] <= '0;
                fp_q[i] <= '0;
                pq_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            prd_q   <= prd_d;
            pwr_q   <= pwr_d;
            if (acc) pq_q[pwr_q] <= pc_q;
            if (keep) begin
                fd_q[wr_q] <= bus.imem_rsp_data;
                fp_q[wr_q] <= pq_q[prd_q];
            end
        end
    end
endmodule
